// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and baud divider helper
//
// Purpose : common definitions for the UART receiver (and the future transmitter).
// Contents: DATA_BITS, FSM state encodings, calc_div() tick divider function.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Receiver FSM state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  // Clock cycles per oversample tick, truncated
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator with synchronous restart
//
// Purpose : emits a one-clock tick every DIV clock cycles.
// Ports   : i_clk   system clock
//           i_reset synchronous active-high reset
//           i_clr   restart the divider (phase-aligns ticks to a start edge)
//           o_tick  one-cycle tick pulse
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A clear in the same cycle wins, so the first tick after a restart is DIV cycles away
  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8N1 (optional parity via UART_RX_PARITY_EN)
//
// Purpose : recovers LSB-first bytes from an asynchronous rx line, forwards only
//           correctly framed bytes, flags framing (and optionally parity) errors.
// Macro   : UART_RX_PARITY_EN - adds a parity bit after the data bits and the parity_err port.
// Ports   : clk         system clock
//           reset       synchronous active-high reset
//           rx          asynchronous serial line, idle high
//           dout        last valid received byte
//           ready       one-cycle pulse, dout holds a new byte
//           framing_err one-cycle pulse, stop bit sampled low
//           parity_err  one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       ready,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       framing_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic [1:0]          r_sync;
  logic                r_rx_prev;
  logic [2:0]          r_state;
  logic [TW-1:0]       r_tick_cnt;
  logic [2:0]          r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                r_ready;
  logic                r_framing_err;

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_baud_clr;

  assign w_rx       = r_sync[1];
  assign w_fall     = r_rx_prev && !w_rx;
  assign w_baud_clr = (r_state == IDLE) && w_fall;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_baud_clr),
    .o_tick  (w_tick)
  );

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic r_parity_bad;
  logic r_parity_err;
  assign parity_err = r_parity_err;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync        <= 2'b11;
      r_rx_prev     <= 1'b1;
      r_state       <= IDLE;
      r_tick_cnt    <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_dout        <= '0;
      r_ready       <= 1'b0;
      r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_bad  <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_sync        <= {r_sync[0], rx};
      r_rx_prev     <= w_rx;
      r_ready       <= 1'b0;
      r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state    <= START;
            r_tick_cnt <= '0;
          end
        end

        START: begin
          if (w_tick) begin
            if (r_tick_cnt == TICK_HALF) begin
              r_tick_cnt <= '0;
              r_bit_idx  <= '0;
              // A start bit that is already high again at mid-bit was noise
              r_state    <= w_rx ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
              r_bit_idx  <= r_bit_idx + 3'd1;
              if (r_bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt   <= '0;
              // Data plus parity bit must have the configured overall parity
              r_parity_bad <= ((^r_shift) ^ w_rx) != PAR_ODD;
              r_state      <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
`endif

        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              if (w_rx) begin
                // Re-arm here so a start edge right after the stop bit is caught
                r_state <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (r_parity_bad) begin
                  r_parity_err <= 1'b1;
                end else begin
                  r_dout  <= r_shift;
                  r_ready <= 1'b1;
                end
`else
                r_dout  <= r_shift;
                r_ready <= 1'b1;
`endif
              end else begin
                r_framing_err <= 1'b1;
                r_state       <= BREAK;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end

        BREAK: begin
          // Single error pulse for a held-low line; wait for the line to recover
          if (w_rx) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dout        = r_dout;
  assign ready       = r_ready;
  assign framing_err = r_framing_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

  // Scaled clock: DIV = 6, one bit period = 96 clk, keeps the run short
  localparam int CLK_FREQ   = 11_059_200;
  localparam int BAUD_RATE  = 115200;
  localparam int OVERSAMPLE = 16;
  localparam int PARITY_ODD = 0;
  localparam int DIV        = 6;
  localparam int BIT        = DIV * OVERSAMPLE;
  // 2 sync stages + edge register, then half a bit plus 9 bits of ticks
  localparam int LATENCY    = 3 + DIV * (OVERSAMPLE / 2 + 9 * OVERSAMPLE);

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] dout;
  logic       ready;
  logic       framing_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int overlap_cnt = 0;
  int last_ready_cyc = 0;
  int t_start = 0;
  logic [7:0] rx_q[$];

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .dout        (dout),
    .ready       (ready),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .framing_err (framing_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready) begin
      ready_cnt++;
      last_ready_cyc = cyc;
      rx_q.push_back(dout);
    end
    if (framing_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
    if (ready && parity_err) overlap_cnt++;
    if (framing_err && parity_err) overlap_cnt++;
`endif
    if (ready && framing_err) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int nbits);
    rx = v;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return (^b) ^ (PARITY_ODD != 0);
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_v, input int stop_bits);
    t_start = cyc;
    drive(1'b0, 1);
    for (int i = 0; i < 8; i++) drive(b[i], 1);
`ifdef UART_RX_PARITY_EN
    drive(par, 1);
`endif
    drive(stop_v, stop_bits);
  endtask

  initial begin
    int n_rdy;
    int n_ferr;
    int n_perr;
    int base;
    logic [127:0] block;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_dout", 128'(dout), 128'h0);
    check("reset_ready", 128'(ready), 128'h0);
    check("reset_framing_err", 128'(framing_err), 128'h0);
    check("reset_state", 128'(dut.r_state), 128'(IDLE));
    reset = 1'b0;
    drive(1'b1, 2);

    // Single byte, latency from start edge
    n_rdy = ready_cnt;
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 1);
    drive(1'b1, 1);
    check("a5_ready_count", 128'(ready_cnt - n_rdy), 128'd1);
    check("a5_dout", 128'(dout), 128'hA5);
    check("a5_latency", 128'(last_ready_cyc - t_start), 128'(LATENCY));

    // Short low glitch is dropped silently
    n_rdy  = ready_cnt;
    n_ferr = ferr_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    drive(1'b1, 2);
    check("glitch_no_ready", 128'(ready_cnt - n_rdy), 128'd0);
    check("glitch_no_ferr", 128'(ferr_cnt - n_ferr), 128'd0);
    check("glitch_state_idle", 128'(dut.r_state), 128'(IDLE));

    // Stop bit held low for 3 bit periods
    n_rdy  = ready_cnt;
    n_ferr = ferr_cnt;
    send_frame(8'h3C, good_par(8'h3C), 1'b0, 3);
    drive(1'b1, 2);
    check("frame_err_count", 128'(ferr_cnt - n_ferr), 128'd1);
    check("frame_err_no_ready", 128'(ready_cnt - n_rdy), 128'd0);
    check("frame_err_dout_kept", 128'(dout), 128'hA5);

    n_rdy = ready_cnt;
    send_frame(8'h11, good_par(8'h11), 1'b1, 1);
    drive(1'b1, 1);
    check("after_ferr_ready", 128'(ready_cnt - n_rdy), 128'd1);
    check("after_ferr_dout", 128'(dout), 128'h11);

    // 16 back-to-back frames with no idle gap
    n_rdy = ready_cnt;
    base  = rx_q.size();
    for (int i = 0; i < 16; i++) send_frame(8'(i), good_par(8'(i)), 1'b1, 1);
    drive(1'b1, 1);
    check("b2b_ready_count", 128'(ready_cnt - n_rdy), 128'd16);
    block = '0;
    for (int i = 0; i < 16; i++) begin
      if (base + i < rx_q.size()) block = {block[119:0], rx_q[base + i]};
    end
    check("b2b_block", block, 128'h000102030405060708090A0B0C0D0E0F);
    check("b2b_dout_last", 128'(dout), 128'h0F);

    // Reset during data bit 4 of 0xFF
    n_rdy  = ready_cnt;
    n_ferr = ferr_cnt;
    drive(1'b0, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1);
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("midframe_state_data", 128'(dut.r_state), 128'(DATA));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midframe_reset_dout", 128'(dout), 128'h0);
    drive(1'b1, 6);
    check("midframe_no_ready", 128'(ready_cnt - n_rdy), 128'd0);
    check("midframe_no_ferr", 128'(ferr_cnt - n_ferr), 128'd0);
    check("midframe_dout_zero", 128'(dout), 128'h0);
    send_frame(8'h5A, good_par(8'h5A), 1'b1, 1);
    drive(1'b1, 1);
    check("post_reset_ready", 128'(ready_cnt - n_rdy), 128'd1);
    check("post_reset_dout", 128'(dout), 128'h5A);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    n_rdy  = ready_cnt;
    n_perr = perr_cnt;
    send_frame(8'h07, 1'b0, 1'b1, 1);
    drive(1'b1, 1);
    check("parity_bad_perr", 128'(perr_cnt - n_perr), 128'd1);
    check("parity_bad_no_ready", 128'(ready_cnt - n_rdy), 128'd0);
    check("parity_bad_dout_kept", 128'(dout), 128'h5A);
    n_rdy  = ready_cnt;
    n_perr = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1);
    drive(1'b1, 1);
    check("parity_ok_ready", 128'(ready_cnt - n_rdy), 128'd1);
    check("parity_ok_no_perr", 128'(perr_cnt - n_perr), 128'd0);
    check("parity_ok_dout", 128'(dout), 128'h07);
    // Bad parity and bad stop: only the framing error is reported
    n_ferr = ferr_cnt;
    n_perr = perr_cnt;
    send_frame(8'h07, 1'b0, 1'b0, 2);
    drive(1'b1, 2);
    check("both_bad_ferr", 128'(ferr_cnt - n_ferr), 128'd1);
    check("both_bad_no_perr", 128'(perr_cnt - n_perr), 128'd0);
`else
    n_perr = perr_cnt;
`endif

    check("pulse_overlap", 128'(overlap_cnt), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
